// File: rtl/playseq_gravador_sequencia.sv
// Records a player-entered button sequence into a 16x4 RAM read by the PlaySeq datapath.
// Latency: rd_data is registered (1 cycle after rd_addr); status outputs change on the edge after the causing event.
// Backpressure: none; presses arriving outside ESPERA (or with finalizar/cancelar) are dropped.
module playseq_gravador_sequencia #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int TIMEOUT_M = 5000,
    parameter int MIN_LEN   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              finalizar,
    input  logic              cancelar,
    input  logic [DATA_W-1:0] botoes,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   comprimento,
    output logic              gravando,
    output logic              pronto,
    output logic              erro,
    output logic              timeout,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_endereco
);

    localparam int CNT_W = (TIMEOUT_M > 2) ? $clog2(TIMEOUT_M) : 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ESPERA   = 4'd1,
        ST_REGISTRA = 4'd2,
        ST_SOLTA    = 4'd3,
        ST_FIM      = 4'd4,
        ST_ERRO     = 4'd5
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     comp_q, comp_d;
    logic                pronto_q, pronto_d;
    logic                timeout_q, timeout_d;
    logic                p_prev_q, p_prev_d;
    logic [DATA_W-1:0]   jogada_q, jogada_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                press, one_hot, len_ok, idle_end, wr_en, inicia, aborta;
    logic [ADDR_W:0]     comp_inc;

    // Next-state, counters and press detection
    always_comb begin
        press     = (|botoes) & ~p_prev_q;
        one_hot   = $onehot(botoes);
        len_ok    = (comp_q >= (ADDR_W+1)'(MIN_LEN));
        idle_end  = (idle_q == CNT_W'(TIMEOUT_M - 1));
        comp_inc  = comp_q + 1'b1;

        estado_d  = estado_q;
        wr_ptr_d  = wr_ptr_q;
        comp_d    = comp_q;
        pronto_d  = pronto_q;
        timeout_d = 1'b0;
        wr_en     = 1'b0;
        inicia    = 1'b0;
        aborta    = 1'b0;

        case (estado_q)
            ST_IDLE: begin
                if (iniciar) inicia = 1'b1;
            end
            ST_ESPERA: begin
                if (cancelar) begin
                    aborta = 1'b1;
                end else if (finalizar) begin
                    estado_d = len_ok ? ST_FIM : ST_ERRO;
                end else if (press) begin
                    estado_d = one_hot ? ST_REGISTRA : ST_ERRO;
                end else if (idle_end) begin
                    timeout_d = 1'b1;
                    estado_d  = len_ok ? ST_FIM : ST_ERRO;
                end
            end
            ST_REGISTRA: begin
                // The write completes even if the recording is being cancelled.
                wr_en  = 1'b1;
                comp_d = comp_inc;
                // Pointer saturates: the full condition ends the recording instead.
                if (wr_ptr_q != ADDR_W'(DEPTH - 1)) wr_ptr_d = wr_ptr_q + 1'b1;
                if (cancelar) begin
                    aborta = 1'b1;
                end else if (comp_inc == (ADDR_W+1)'(DEPTH)) begin
                    estado_d = ST_FIM;
                end else begin
                    estado_d = ST_SOLTA;
                end
            end
            ST_SOLTA: begin
                if (cancelar) begin
                    aborta = 1'b1;
                end else if (botoes == '0) begin
                    estado_d = ST_ESPERA;
                end
            end
            ST_FIM: begin
                if (iniciar) inicia = 1'b1;
            end
            ST_ERRO: begin
                if (cancelar) begin
                    aborta = 1'b1;
                end else if (iniciar) begin
                    inicia = 1'b1;
                end
            end
            default: estado_d = ST_IDLE;
        endcase

        if (inicia) begin
            estado_d = ST_ESPERA;
            wr_ptr_d = '0;
            comp_d   = '0;
            pronto_d = 1'b0;
        end
        if (aborta) begin
            estado_d = ST_IDLE;
            wr_ptr_d = '0;
            comp_d   = '0;
            pronto_d = 1'b0;
        end
        if (estado_d == ST_FIM)  pronto_d = 1'b1;
        if (estado_d == ST_ERRO) pronto_d = 1'b0;

        // Idle counter restarts on every state entry and only advances while waiting.
        idle_d = idle_q;
        if ((estado_d != estado_q) || inicia) begin
            idle_d = '0;
        end else if ((estado_q == ST_ESPERA) && !idle_end) begin
            idle_d = idle_q + 1'b1;
        end

        jogada_d  = (press && one_hot) ? botoes : jogada_q;
        p_prev_d  = |botoes;
        rd_data_d = mem[rd_addr];
    end

    // State and status registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= ST_IDLE;
            wr_ptr_q  <= '0;
            comp_q    <= '0;
            pronto_q  <= 1'b0;
            timeout_q <= 1'b0;
            p_prev_q  <= 1'b0;
            jogada_q  <= '0;
            idle_q    <= '0;
            rd_data_q <= '0;
        end else begin
            estado_q  <= estado_d;
            wr_ptr_q  <= wr_ptr_d;
            comp_q    <= comp_d;
            pronto_q  <= pronto_d;
            timeout_q <= timeout_d;
            p_prev_q  <= p_prev_d;
            jogada_q  <= jogada_d;
            idle_q    <= idle_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Sequence RAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= jogada_q;
    end

    assign rd_data     = rd_data_q;
    assign comprimento = comp_q;
    assign pronto      = pronto_q;
    assign timeout     = timeout_q;
    assign gravando    = (estado_q == ST_ESPERA) || (estado_q == ST_REGISTRA) || (estado_q == ST_SOLTA);
    assign erro        = (estado_q == ST_ERRO);
    assign db_estado   = estado_q;
    assign db_endereco = wr_ptr_q;

endmodule

// File: tb/tb_playseq_gravador_sequencia.sv
// Bench for the sequence recorder: random and directed stimulus against a reference model.
// Expected outputs are queued at each clock edge and checked by an independent monitor.
// All inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_playseq_gravador_sequencia;

    localparam int TO      = 64;
    localparam int MIN_LEN = 4;
    localparam int DEPTH   = 16;

    logic       clock, reset, iniciar, finalizar, cancelar;
    logic [3:0] botoes, rd_addr, rd_data;
    logic [4:0] comprimento;
    logic       gravando, pronto, erro, timeout;
    logic [3:0] db_estado, db_endereco;

    playseq_gravador_sequencia #(.TIMEOUT_M(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .finalizar(finalizar),
        .cancelar(cancelar), .botoes(botoes), .rd_addr(rd_addr), .rd_data(rd_data),
        .comprimento(comprimento), .gravando(gravando), .pronto(pronto), .erro(erro),
        .timeout(timeout), .db_estado(db_estado), .db_endereco(db_endereco)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int tmo_seen = 0;
    bit rand_rd  = 1'b1;

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   st;
        int   len;
        int   wp;
        bit   pr;
        bit   tmo;
        int   rd;
        bit   rdv;
    } exp_t;

    exp_t exp_q[$];

    int   m_st = 0, m_len = 0, m_wp = 0, m_idle = 0, m_jog = 0, m_nst;
    bit   m_prev = 0, m_pr = 0, m_tmo = 0, m_press, m_onehot, m_start, m_abort;
    int   m_mem  [DEPTH];
    bit   m_memv [DEPTH];
    exp_t m_e;

    initial for (int i = 0; i < DEPTH; i++) m_memv[i] = 1'b0;

    always @(posedge clock) begin
        if (!reset) begin
            m_st = 0; m_len = 0; m_wp = 0; m_idle = 0; m_jog = 0;
            m_prev = 0; m_pr = 0; m_tmo = 0;
            m_e.rd = 0; m_e.rdv = 1'b1;
        end else begin
            m_e.rd  = m_mem[rd_addr];
            m_e.rdv = m_memv[rd_addr];
            m_press  = (botoes != 0) && !m_prev;
            m_onehot = ($countones(botoes) == 1);
            m_tmo = 0; m_nst = m_st; m_start = 0; m_abort = 0;
            case (m_st)
                0: if (iniciar) m_start = 1;
                1: begin
                    if (cancelar)                m_abort = 1;
                    else if (finalizar)          m_nst = (m_len >= MIN_LEN) ? 4 : 5;
                    else if (m_press)            m_nst = m_onehot ? 2 : 5;
                    else if (m_idle == TO - 1) begin
                        m_tmo = 1;
                        m_nst = (m_len >= MIN_LEN) ? 4 : 5;
                    end
                end
                2: begin
                    m_mem[m_wp] = m_jog; m_memv[m_wp] = 1'b1;
                    m_len++;
                    if (m_wp < DEPTH - 1) m_wp++;
                    if (cancelar) m_abort = 1;
                    else          m_nst = (m_len == DEPTH) ? 4 : 3;
                end
                3: begin
                    if (cancelar)         m_abort = 1;
                    else if (botoes == 0) m_nst = 1;
                end
                4: if (iniciar) m_start = 1;
                5: begin
                    if (cancelar)     m_abort = 1;
                    else if (iniciar) m_start = 1;
                end
                default: m_nst = 0;
            endcase
            if (m_start) begin m_nst = 1; m_len = 0; m_wp = 0; m_pr = 0; end
            if (m_abort) begin m_nst = 0; m_len = 0; m_wp = 0; m_pr = 0; end
            if (m_nst == 4) m_pr = 1;
            if (m_nst == 5) m_pr = 0;
            if (m_nst != m_st || m_start) m_idle = 0;
            else if (m_st == 1)           m_idle++;
            if (m_press && m_onehot) m_jog = botoes;
            m_prev = (botoes != 0);
            m_st = m_nst;
        end
        m_e.st = m_st; m_e.len = m_len; m_e.wp = m_wp; m_e.pr = m_pr; m_e.tmo = m_tmo;
        exp_q.push_back(m_e);
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        if (timeout) tmo_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("db_estado",   db_estado,   e.st);
            cmp("comprimento", comprimento, e.len);
            cmp("db_endereco", db_endereco, e.wp);
            cmp("pronto",      pronto,      e.pr);
            cmp("timeout",     timeout,     e.tmo);
            cmp("gravando",    gravando,    (e.st >= 1 && e.st <= 3) ? 1 : 0);
            cmp("erro",        erro,        (e.st == 5) ? 1 : 0);
            if (e.rdv) cmp("rd_data", rd_data, e.rd);
        end
    end

    // Random read address every cycle unless a directed read is in progress
    always @(negedge clock) begin
        #1;
        if (rand_rd) rd_addr = 4'($urandom);
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_ini();
        iniciar = 1'b1; wait_cyc(1); iniciar = 1'b0;
    endtask

    task automatic pulse_fin();
        finalizar = 1'b1; wait_cyc(1); finalizar = 1'b0;
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int rel);
        botoes = v; wait_cyc(hold); botoes = 4'd0; wait_cyc(rel);
    endtask

    task automatic read_at(input logic [3:0] a, input int exp, input string name);
        rand_rd = 1'b0; rd_addr = a; wait_cyc(1);
        cmp(name, rd_data, exp);
        rand_rd = 1'b1;
    endtask

    initial begin
        logic [3:0] seq2 [4];
        int         t0, r;
        seq2[0] = 4'b0001; seq2[1] = 4'b0100; seq2[2] = 4'b1000; seq2[3] = 4'b0010;

        reset = 1'b0; iniciar = 0; finalizar = 0; cancelar = 0; botoes = 0; rd_addr = 0;
        wait_cyc(3);
        cmp("reset_rd_data", rd_data, 0);
        reset = 1'b1;
        wait_cyc(2);
        cmp("reset_estado", db_estado, 0);

        // Four valid presses then finalizar: valid recording
        pulse_ini();
        for (int i = 0; i < 4; i++) press(seq2[i], 3, 2);
        pulse_fin(); wait_cyc(1);
        cmp("t2_estado", db_estado, 4);
        cmp("t2_comprimento", comprimento, 4);
        cmp("t2_pronto", pronto, 1);
        for (int i = 0; i < 4; i++) read_at(4'(i), seq2[i], "t2_read");

        // Too short: ERRO
        pulse_ini();
        press(4'b0010, 3, 2); press(4'b0010, 3, 2);
        pulse_fin(); wait_cyc(1);
        cmp("t3_estado", db_estado, 5);
        cmp("t3_comprimento", comprimento, 2);
        cmp("t3_pronto", pronto, 0);

        // Multi-button press: ERRO, no write
        pulse_ini(); wait_cyc(1);
        botoes = 4'b0011; wait_cyc(1);
        cmp("t4_estado", db_estado, 5);
        botoes = 4'b0000; wait_cyc(2);
        read_at(4'd0, 4'b0010, "t4_read_prior");

        // Full memory ends the recording
        pulse_ini();
        for (int i = 0; i < DEPTH; i++) press(4'(1 << $urandom_range(0, 3)), 1 + $urandom_range(0, 2), 2);
        cmp("t5_estado", db_estado, 4);
        cmp("t5_comprimento", comprimento, 16);
        cmp("t5_pronto", pronto, 1);
        press(4'b0100, 2, 2);
        cmp("t5_extra_ignored", comprimento, 16);

        // Idle timeout after five presses; long hold records once
        pulse_ini();
        for (int i = 0; i < 4; i++) press(4'(1 << i), 2, 2);
        press(4'b1000, 100, 2);
        cmp("t6_long_hold", comprimento, 5);
        t0 = tmo_seen;
        wait_cyc(TO + 10);
        cmp("t6_timeout_pulses", tmo_seen - t0, 1);
        cmp("t6_estado", db_estado, 4);
        cmp("t6_comprimento", comprimento, 5);

        // Reset in the middle of a recording
        pulse_ini(); press(4'b0001, 2, 2);
        botoes = 4'b0100; wait_cyc(1);
        reset = 1'b0; botoes = 4'b0000; wait_cyc(2);
        cmp("t1_rd_data", rd_data, 0);
        reset = 1'b1; wait_cyc(1);
        cmp("t1_estado", db_estado, 0);
        cmp("t1_comprimento", comprimento, 0);
        cmp("t1_pronto", pronto, 0);

        // Randomized traffic, checked only by the scoreboard
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       pulse_ini();
            else if (r < 12) pulse_fin();
            else if (r < 15) begin cancelar = 1'b1; wait_cyc(1); cancelar = 1'b0; end
            else if (r < 16) begin reset = 1'b0; wait_cyc($urandom_range(1, 2)); reset = 1'b1; end
            else if (r < 82) begin
                if ($urandom_range(0, 4) == 0) press(4'($urandom), $urandom_range(1, 4), $urandom_range(0, 3));
                else press(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 4), $urandom_range(0, 3));
            end
            else if (r < 85) wait_cyc(TO + $urandom_range(0, 4));
            else             wait_cyc($urandom_range(1, 8));
        end

        wait_cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
